// File: rtl/pipe_pkg.sv
// Shared types and widths for the decode-to-ALU pipeline slice.
// Holds the ID/EX register bundle and the forwarding-select enum.
package pipe_pkg;

  localparam int DATA_WIDTH     = 24;
  localparam int REG_ADDR_WIDTH = 4;
  localparam int ALU_OP_WIDTH   = 4;
  localparam int CNT_WIDTH      = 16;

  typedef logic [DATA_WIDTH-1:0]     data_t;
  typedef logic [REG_ADDR_WIDTH-1:0] addr_t;
  typedef logic [ALU_OP_WIDTH-1:0]   op_t;

  typedef enum logic [1:0] {
    FWD_REG,
    FWD_MEM,
    FWD_WB
  } fwd_sel_t;

  typedef struct packed {
    logic  valid;
    logic  wb_en;
    logic  mem_rd;
    logic  mem_wr;
    logic  alu_src_imm;
    op_t   alu_op;
    addr_t dest;
    addr_t src1_addr;
    addr_t src2_addr;
    data_t src1_data;
    data_t src2_data;
    data_t imm;
  } id_ex_t;

  // Register-file read with a same-edge writeback bypass.
  function automatic data_t wb_bypass(
    input addr_t src_addr,
    input data_t src_data,
    input logic  wb_en,
    input addr_t wb_dest,
    input data_t wb_data
  );
    if (wb_en && (wb_dest == src_addr))
      return wb_data;
    return src_data;
  endfunction

endpackage

// File: rtl/operand_forward.sv
// Operand forwarding: picks MEM result, WB data or the latched value.
// Ports: addr/reg_data (latched operand), MEM and WB feedback, fwd_data.
module operand_forward
  import pipe_pkg::*;
(
  input  logic [REG_ADDR_WIDTH-1:0] addr,
  input  logic [DATA_WIDTH-1:0]     reg_data,
  input  logic                      mem_writeback_enable,
  input  logic                      mem_stage_read,
  input  logic [REG_ADDR_WIDTH-1:0] mem_dest,
  input  logic [DATA_WIDTH-1:0]     mem_alu_result,
  input  logic                      wb_writeback_enable,
  input  logic [REG_ADDR_WIDTH-1:0] wb_dest,
  input  logic [DATA_WIDTH-1:0]     wb_data,
  output logic [DATA_WIDTH-1:0]     fwd_data
);

  fwd_sel_t sel;
  logic     mem_hit;
  logic     wb_hit;

  // A load in MEM has no data yet; its value only arrives via WB.
  assign mem_hit = mem_writeback_enable && !mem_stage_read &&
                   (mem_dest == addr);
  assign wb_hit  = wb_writeback_enable && (wb_dest == addr);

  // MEM is the younger producer, so it wins over WB.
  always_comb begin
    sel = FWD_REG;
    if (mem_hit)
      sel = FWD_MEM;
    else if (wb_hit)
      sel = FWD_WB;
  end

  always_comb begin
    fwd_data = reg_data;
    unique case (sel)
      FWD_MEM: fwd_data = mem_alu_result;
      FWD_WB:  fwd_data = wb_data;
      FWD_REG: fwd_data = reg_data;
      default: fwd_data = reg_data;
    endcase
  end

endmodule

// File: rtl/decode_alu_pipe.sv
// Decode-to-ALU pipeline register with load-use stall and forwarding.
// Ports: decode fields in, MEM/WB feedback in, ALU fields/operands out.
module decode_alu_pipe
  import pipe_pkg::*;
(
  input  logic                      clk,
  input  logic                      rst,
  input  logic                      flush,
  input  logic                      valid_in,
  input  logic                      writeback_enable,
  input  logic                      mem_read_enable,
  input  logic                      mem_write_enable,
  input  logic                      alu_src_imm,
  input  logic [ALU_OP_WIDTH-1:0]   alu_op,
  input  logic                      src1_used,
  input  logic                      src2_used,
  input  logic [REG_ADDR_WIDTH-1:0] src1_addr,
  input  logic [REG_ADDR_WIDTH-1:0] src2_addr,
  input  logic [REG_ADDR_WIDTH-1:0] instruction_dest,
  input  logic [DATA_WIDTH-1:0]     src1_data,
  input  logic [DATA_WIDTH-1:0]     src2_data,
  input  logic [DATA_WIDTH-1:0]     immediate,
  input  logic                      mem_writeback_enable,
  input  logic                      mem_stage_read,
  input  logic [REG_ADDR_WIDTH-1:0] mem_dest,
  input  logic [DATA_WIDTH-1:0]     mem_alu_result,
  input  logic                      wb_writeback_enable,
  input  logic [REG_ADDR_WIDTH-1:0] wb_dest,
  input  logic [DATA_WIDTH-1:0]     wb_data,
  output logic                      stall,
  output logic                      valid_out,
  output logic                      writeback_enable_out,
  output logic                      mem_read_enable_out,
  output logic                      mem_write_enable_out,
  output logic [ALU_OP_WIDTH-1:0]   alu_op_out,
  output logic [REG_ADDR_WIDTH-1:0] instruction_dest_out,
  output logic [DATA_WIDTH-1:0]     operand_a,
  output logic [DATA_WIDTH-1:0]     operand_b,
  output logic [DATA_WIDTH-1:0]     write_data_out,
  output logic [CNT_WIDTH-1:0]      bubble_count
);

  id_ex_t               q;
  id_ex_t               nxt;
  logic                 src1_dep;
  logic                 src2_dep;
  logic [CNT_WIDTH-1:0] bubble_q;
  logic [DATA_WIDTH-1:0] fwd_a;
  logic [DATA_WIDTH-1:0] fwd_b;

  assign src1_dep = src1_used && (src1_addr == q.dest);
  assign src2_dep = src2_used && (src2_addr == q.dest);

  // Only a load in EX can't be forwarded in time; flush kills the
  // consumer anyway, and reset forces a clean empty pipe.
  assign stall = !rst && !flush && valid_in &&
                 q.valid && q.mem_rd && q.wb_en &&
                 (src1_dep || src2_dep);

  always_comb begin
    nxt = '0;
    if (!flush && !stall) begin
      nxt.valid       = valid_in;
      nxt.wb_en       = writeback_enable;
      nxt.mem_rd      = mem_read_enable;
      nxt.mem_wr      = mem_write_enable;
      nxt.alu_src_imm = alu_src_imm;
      nxt.alu_op      = alu_op;
      nxt.dest        = instruction_dest;
      nxt.src1_addr   = src1_addr;
      nxt.src2_addr   = src2_addr;
      nxt.src1_data   = wb_bypass(src1_addr, src1_data,
                                  wb_writeback_enable,
                                  wb_dest, wb_data);
      nxt.src2_data   = wb_bypass(src2_addr, src2_data,
                                  wb_writeback_enable,
                                  wb_dest, wb_data);
      nxt.imm         = immediate;
    end
  end

  always_ff @(posedge clk) begin
    if (rst)
      q <= '0;
    else
      q <= nxt;
  end

  always_ff @(posedge clk) begin
    if (rst)
      bubble_q <= '0;
    else if (stall && (bubble_q != '1))
      bubble_q <= bubble_q + 16'd1;
  end

  operand_forward u_fwd_a (
    .addr                 (q.src1_addr),
    .reg_data             (q.src1_data),
    .mem_writeback_enable (mem_writeback_enable),
    .mem_stage_read       (mem_stage_read),
    .mem_dest             (mem_dest),
    .mem_alu_result       (mem_alu_result),
    .wb_writeback_enable  (wb_writeback_enable),
    .wb_dest              (wb_dest),
    .wb_data              (wb_data),
    .fwd_data             (fwd_a)
  );

  operand_forward u_fwd_b (
    .addr                 (q.src2_addr),
    .reg_data             (q.src2_data),
    .mem_writeback_enable (mem_writeback_enable),
    .mem_stage_read       (mem_stage_read),
    .mem_dest             (mem_dest),
    .mem_alu_result       (mem_alu_result),
    .wb_writeback_enable  (wb_writeback_enable),
    .wb_dest              (wb_dest),
    .wb_data              (wb_data),
    .fwd_data             (fwd_b)
  );

  assign valid_out            = q.valid;
  assign writeback_enable_out = q.wb_en;
  assign mem_read_enable_out  = q.mem_rd;
  assign mem_write_enable_out = q.mem_wr;
  assign alu_op_out           = q.alu_op;
  assign instruction_dest_out = q.dest;
  assign operand_a            = fwd_a;
  assign operand_b            = q.alu_src_imm ? q.imm : fwd_b;
  assign write_data_out       = fwd_b;
  assign bubble_count         = bubble_q;

endmodule

// File: tb/tb_decode_alu_pipe.sv
// Directed bench for decode_alu_pipe: reset, load-use, forwarding,
// flush, reset mid-stall and counter saturation.
module tb_decode_alu_pipe;

  logic        clk = 1'b0;
  logic        rst;
  logic        flush;
  logic        valid_in;
  logic        writeback_enable;
  logic        mem_read_enable;
  logic        mem_write_enable;
  logic        alu_src_imm;
  logic [3:0]  alu_op;
  logic        src1_used;
  logic        src2_used;
  logic [3:0]  src1_addr;
  logic [3:0]  src2_addr;
  logic [3:0]  instruction_dest;
  logic [23:0] src1_data;
  logic [23:0] src2_data;
  logic [23:0] immediate;
  logic        mem_writeback_enable;
  logic        mem_stage_read;
  logic [3:0]  mem_dest;
  logic [23:0] mem_alu_result;
  logic        wb_writeback_enable;
  logic [3:0]  wb_dest;
  logic [23:0] wb_data;
  logic        stall;
  logic        valid_out;
  logic        writeback_enable_out;
  logic        mem_read_enable_out;
  logic        mem_write_enable_out;
  logic [3:0]  alu_op_out;
  logic [3:0]  instruction_dest_out;
  logic [23:0] operand_a;
  logic [23:0] operand_b;
  logic [23:0] write_data_out;
  logic [15:0] bubble_count;

  int tests = 0;
  int fails = 0;

  always #5 clk = ~clk;

  decode_alu_pipe dut (
    .clk                  (clk),
    .rst                  (rst),
    .flush                (flush),
    .valid_in             (valid_in),
    .writeback_enable     (writeback_enable),
    .mem_read_enable      (mem_read_enable),
    .mem_write_enable     (mem_write_enable),
    .alu_src_imm          (alu_src_imm),
    .alu_op               (alu_op),
    .src1_used            (src1_used),
    .src2_used            (src2_used),
    .src1_addr            (src1_addr),
    .src2_addr            (src2_addr),
    .instruction_dest     (instruction_dest),
    .src1_data            (src1_data),
    .src2_data            (src2_data),
    .immediate            (immediate),
    .mem_writeback_enable (mem_writeback_enable),
    .mem_stage_read       (mem_stage_read),
    .mem_dest             (mem_dest),
    .mem_alu_result       (mem_alu_result),
    .wb_writeback_enable  (wb_writeback_enable),
    .wb_dest              (wb_dest),
    .wb_data              (wb_data),
    .stall                (stall),
    .valid_out            (valid_out),
    .writeback_enable_out (writeback_enable_out),
    .mem_read_enable_out  (mem_read_enable_out),
    .mem_write_enable_out (mem_write_enable_out),
    .alu_op_out           (alu_op_out),
    .instruction_dest_out (instruction_dest_out),
    .operand_a            (operand_a),
    .operand_b            (operand_b),
    .write_data_out       (write_data_out),
    .bubble_count         (bubble_count)
  );

  task automatic chk(input string tag,
                     input logic [31:0] obs,
                     input logic [31:0] exp);
    tests++;
    assert (obs === exp) else begin
      fails++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic dec(input logic v, input logic wb,
                     input logic mr, input logic mw,
                     input logic ims, input logic [3:0] op,
                     input logic s1u, input logic [3:0] s1a,
                     input logic [23:0] s1d,
                     input logic s2u, input logic [3:0] s2a,
                     input logic [23:0] s2d,
                     input logic [3:0] dst,
                     input logic [23:0] imv);
    valid_in         = v;
    writeback_enable = wb;
    mem_read_enable  = mr;
    mem_write_enable = mw;
    alu_src_imm      = ims;
    alu_op           = op;
    src1_used        = s1u;
    src1_addr        = s1a;
    src1_data        = s1d;
    src2_used        = s2u;
    src2_addr        = s2a;
    src2_data        = s2d;
    instruction_dest = dst;
    immediate        = imv;
  endtask

  task automatic mem_fb(input logic we, input logic rd,
                        input logic [3:0] d,
                        input logic [23:0] r);
    mem_writeback_enable = we;
    mem_stage_read       = rd;
    mem_dest             = d;
    mem_alu_result       = r;
  endtask

  task automatic wb_fb(input logic we, input logic [3:0] d,
                       input logic [23:0] r);
    wb_writeback_enable = we;
    wb_dest             = d;
    wb_data             = r;
  endtask

  initial begin
    rst   = 1'b1;
    flush = 1'b0;
    mem_fb(1'b0, 1'b0, 4'd0, 24'h0);
    wb_fb(1'b0, 4'd0, 24'h0);
    // Reset held two cycles with a live load at decode.
    dec(1'b1, 1'b1, 1'b1, 1'b1, 1'b1, 4'hA,
        1'b1, 4'd3, 24'h123456, 1'b1, 4'd3, 24'h654321,
        4'd3, 24'h00ABCD);
    #1;
    chk("rst_stall_pre", stall, 0);
    tick();
    chk("rst_stall", stall, 0);
    tick();
    chk("rst_valid", valid_out, 0);
    chk("rst_wb", writeback_enable_out, 0);
    chk("rst_mrd", mem_read_enable_out, 0);
    chk("rst_mwr", mem_write_enable_out, 0);
    chk("rst_op", alu_op_out, 0);
    chk("rst_dest", instruction_dest_out, 0);
    chk("rst_opa", operand_a, 0);
    chk("rst_opb", operand_b, 0);
    chk("rst_wdata", write_data_out, 0);
    chk("rst_cnt", bubble_count, 0);
    chk("rst_stall_hold", stall, 0);

    // Load dest=3 enters EX.
    rst = 1'b0;
    dec(1'b1, 1'b1, 1'b1, 1'b0, 1'b1, 4'h1,
        1'b1, 4'd1, 24'h000100, 1'b0, 4'd0, 24'h0,
        4'd3, 24'h000010);
    #1;
    chk("ld_nostall", stall, 0);
    tick();
    chk("ld_valid", valid_out, 1);
    chk("ld_mrd", mem_read_enable_out, 1);
    chk("ld_dest", instruction_dest_out, 3);
    chk("ld_opa", operand_a, 24'h000100);
    chk("ld_opb_imm", operand_b, 24'h000010);

    // Dependent on r3 at decode: one-cycle stall.
    dec(1'b1, 1'b1, 1'b0, 1'b0, 1'b0, 4'h2,
        1'b1, 4'd3, 24'h000555, 1'b1, 4'd5, 24'h000020,
        4'd6, 24'h0);
    #1;
    chk("lu_stall", stall, 1);
    tick();
    chk("lu_bubble", valid_out, 0);
    chk("lu_bubble_wb", writeback_enable_out, 0);
    chk("lu_cnt", bubble_count, 1);
    chk("lu_stall_once", stall, 0);
    // Load now in MEM; dependent enters EX next edge.
    mem_fb(1'b1, 1'b1, 4'd3, 24'h000BAD);
    tick();
    // Load now in WB: r3 must come from wb_data.
    mem_fb(1'b0, 1'b0, 4'd0, 24'h0);
    wb_fb(1'b1, 4'd3, 24'h00000A);
    #1;
    chk("lu_dep_valid", valid_out, 1);
    chk("lu_opa_wb", operand_a, 24'h00000A);
    chk("lu_opb", operand_b, 24'h000020);
    chk("lu_wdata", write_data_out, 24'h000020);
    chk("lu_op", alu_op_out, 2);
    chk("lu_dest", instruction_dest_out, 6);
    chk("lu_cnt_hold", bubble_count, 1);

    // Capture-time bypass: r3 read while WB writes r3.
    dec(1'b1, 1'b1, 1'b0, 1'b0, 1'b0, 4'h3,
        1'b1, 4'd3, 24'h000777, 1'b0, 4'd0, 24'h0,
        4'd9, 24'h0);
    tick();
    wb_fb(1'b0, 4'd0, 24'h0);
    #1;
    chk("cap_bypass", operand_a, 24'h00000A);

    // MEM forwarding on src2 with register operand_b.
    dec(1'b1, 1'b1, 1'b0, 1'b0, 1'b0, 4'h3,
        1'b1, 4'd1, 24'h000011, 1'b1, 4'd2, 24'h000022,
        4'd7, 24'h0);
    tick();
    valid_in = 1'b0;
    mem_fb(1'b1, 1'b0, 4'd2, 24'h000005);
    #1;
    chk("mem_opb", operand_b, 24'h000005);
    chk("mem_wdata", write_data_out, 24'h000005);
    chk("mem_opa", operand_a, 24'h000011);
    mem_stage_read = 1'b1;
    #1;
    chk("mem_load_nofwd", operand_b, 24'h000022);

    // MEM and WB both match: MEM wins.
    mem_fb(1'b0, 1'b0, 4'd0, 24'h0);
    dec(1'b1, 1'b1, 1'b0, 1'b0, 1'b0, 4'h4,
        1'b1, 4'd4, 24'h000044, 1'b0, 4'd0, 24'h0,
        4'd1, 24'h0);
    tick();
    valid_in = 1'b0;
    mem_fb(1'b1, 1'b0, 4'd4, 24'h000007);
    wb_fb(1'b1, 4'd4, 24'h000009);
    #1;
    chk("prio_mem", operand_a, 24'h000007);
    mem_writeback_enable = 1'b0;
    #1;
    chk("prio_wb", operand_a, 24'h000009);
    mem_fb(1'b0, 1'b0, 4'd0, 24'h0);
    wb_fb(1'b0, 4'd0, 24'h0);

    // Flush during a load-use hazard.
    dec(1'b1, 1'b1, 1'b1, 1'b0, 1'b1, 4'h1,
        1'b1, 4'd0, 24'h0, 1'b0, 4'd0, 24'h0,
        4'd8, 24'h000004);
    tick();
    dec(1'b1, 1'b1, 1'b0, 1'b0, 1'b0, 4'h2,
        1'b1, 4'd8, 24'h0, 1'b0, 4'd0, 24'h0,
        4'd2, 24'h0);
    flush = 1'b1;
    #1;
    chk("fl_stall", stall, 0);
    tick();
    flush = 1'b0;
    chk("fl_bubble", valid_out, 0);
    chk("fl_cnt", bubble_count, 1);

    // Reset while a stall is pending.
    dec(1'b1, 1'b1, 1'b1, 1'b0, 1'b1, 4'h1,
        1'b1, 4'd0, 24'h0, 1'b0, 4'd0, 24'h0,
        4'd8, 24'h000004);
    tick();
    dec(1'b1, 1'b1, 1'b0, 1'b0, 1'b0, 4'h2,
        1'b1, 4'd8, 24'h0, 1'b0, 4'd0, 24'h0,
        4'd2, 24'h0);
    #1;
    chk("rs_pre_stall", stall, 1);
    rst = 1'b1;
    #1;
    chk("rs_stall", stall, 0);
    tick();
    rst = 1'b0;
    chk("rs_valid", valid_out, 0);
    chk("rs_cnt", bubble_count, 0);

    // Self-dependent loads stall every other cycle.
    dec(1'b1, 1'b1, 1'b1, 1'b0, 1'b1, 4'h1,
        1'b1, 4'd9, 24'h0, 1'b0, 4'd0, 24'h0,
        4'd9, 24'h000001);
    repeat (6) tick();
    chk("sat_cnt3", bubble_count, 3);
    force dut.bubble_q = 16'hFFFD;
    #1;
    release dut.bubble_q;
    #1;
    chk("sat_forced", bubble_count, 16'hFFFD);
    repeat (4) tick();
    chk("sat_ffff", bubble_count, 16'hFFFF);
    tick();
    chk("sat_stall", stall, 1);
    tick();
    chk("sat_hold", bubble_count, 16'hFFFF);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule

// File: doc/decode_alu_pipe.md
# decode_alu_pipe

Decode-to-ALU pipeline register of the 24-bit core, sitting directly upstream of the ALU→MEM→WB path. It latches decoded control and operands each cycle and detects load-use hazards, holding decode and inserting a bubble. It resolves operand forwarding from the ALU_MEM and MEM_WB stage outputs, so the ALU always sees correct operands. It also counts inserted bubbles for bring-up diagnostics.

## Interface
- DATA_WIDTH, 24, operand/result width
- REG_ADDR_WIDTH, 4, register address width (16 registers, none hardwired)
- ALU_OP_WIDTH, 4, ALU opcode width

Ports (one clock `clk`; reset `rst` is synchronous and active-high):
- clk  in  1  clock
- rst  in  1  synchronous active-high reset
- flush  in  1  discard decode instruction (branch taken)
- valid_in  in  1  decode holds a real instruction
- writeback_enable, mem_read_enable, mem_write_enable, alu_src_imm  in  1 each  decoded control
- alu_op  in  ALU_OP_WIDTH  ALU operation
- src1_used, src2_used  in  1 each  operand actually read
- src1_addr, src2_addr, instruction_dest  in  REG_ADDR_WIDTH  register addresses
- src1_data, src2_data, immediate  in  DATA_WIDTH  register-file reads / immediate
- mem_writeback_enable, mem_stage_read  in  1 each  ALU_MEM register control
- mem_dest  in  REG_ADDR_WIDTH; mem_alu_result  in  DATA_WIDTH  ALU_MEM register outputs
- wb_writeback_enable  in  1; wb_dest  in  REG_ADDR_WIDTH; wb_data  in  DATA_WIDTH  MEM_WB outputs
- stall  out  1  hold fetch/decode this cycle
- valid_out, writeback_enable_out, mem_read_enable_out, mem_write_enable_out  out  1 each
- alu_op_out  out  ALU_OP_WIDTH; instruction_dest_out  out  REG_ADDR_WIDTH
- operand_a, operand_b, write_data_out  out  DATA_WIDTH  forwarded ALU/store operands
- bubble_count  out  16  saturating load-use bubble count

## Operation
- Hazard: stall = !flush && valid_in && valid_out && mem_read_enable_out && writeback_enable_out && ((src1_used && src1_addr==instruction_dest_out) || (src2_used && src2_addr==instruction_dest_out)).
- Capture priority on each edge: rst > flush > stall > load.
  - rst: all registered fields 0.
  - flush or stall: load bubble (valid_out, all enables 0; data fields don't-care, cleared to 0).
  - otherwise: load all decode fields.
- Capture-time bypass: if wb_writeback_enable && wb_dest==srcN_addr, latch wb_data instead of srcN_data.
- Forwarding per operand on latched address (combinational), priority:
  - MEM: mem_writeback_enable && !mem_stage_read && mem_dest==addr → mem_alu_result.
  - WB: wb_writeback_enable && wb_dest==addr → wb_data.
  - otherwise latched data.
- operand_a = forwarded src1; write_data_out = forwarded src2; operand_b = alu_src_imm ? immediate : forwarded src2.
- bubble_count increments by 1 on every stall bubble (not flush), saturates at 0xFFFF, cleared only by rst.

## Timing
- Reset values: every output 0, stall 0 during rst cycle.
- Latency: 1 cycle decode → ALU for registered fields. Forwarded operands are same-cycle combinational from register plus feedback ports.
- Load-use stall lasts exactly one cycle. Next cycle the load is in MEM, so no repeat stall. The dependent reaches ALU while the load is in WB and forwards wb_data.
- flush and hazard together: flush wins, stall=0, bubble_count unchanged.
- rst mid-stall: next cycle clean empty pipe, stall 0, count 0.
- Both forwarding sources match: MEM wins (younger).

## Structure
- Shared package pipe_pkg: DATA_WIDTH, REG_ADDR_WIDTH, ALU_OP_WIDTH constants; enum fwd_sel_t {FWD_REG, FWD_MEM, FWD_WB}.
- Sub-module operand_forward (combinational select + mux), instantiated for src1 and src2. Hazard logic, register and counter stay in the top.

## Test plan
- Reset: hold rst 2 cycles with valid_in=1 → all outputs 0, bubble_count 0.
- Load-use: load dest=3 enters, next decode src1_addr=3 → stall=1 one cycle, bubble (valid_out=0), bubble_count=1; then dependent enters with wb_dest=3, wb_data=0x00000A → operand_a=0x00000A.
- MEM forwarding: ALU op dest=2 in MEM (mem_alu_result=0x000005), EX src2=2, alu_src_imm=0 → operand_b=0x000005; with mem_stage_read=1 → falls to latched data.
- Priority: mem_dest=wb_dest=4, 0x000007 vs 0x000009 → operand_a=0x000007.
- Flush with hazard: flush=1 during load-use condition → stall=0, bubble loaded, bubble_count unchanged.
- Saturation: force 65536 stalls → bubble_count stays 0xFFFF.
